// File: rtl/psa_pkg.sv
// rtl/psa_pkg.sv - shared constants and saturation helper for psa_16bit
package psa_pkg;

    localparam int WIDTH = 16;
    localparam int NIB   = 4;
    localparam int NUM_NIBS = WIDTH / NIB;

    localparam logic [NIB-1:0] SAT_POS_NIB = 4'h7;
    localparam logic [NIB-1:0] SAT_NEG_NIB = 4'h8;

    // Clamp value for an overflowing nibble; the operand sign gives the direction.
    function automatic logic [NIB-1:0] sat_nib(input logic operand_sign);
        return operand_sign ? SAT_NEG_NIB : SAT_POS_NIB;
    endfunction

endpackage

// File: rtl/cla_4bit.sv
// rtl/cla_4bit.sv - 4-bit carry-lookahead adder slice with signed overflow and group P/G
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       ovf,
    output logic       p_g,
    output logic       g_g
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);

    assign p_g = &w_p;
    assign g_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

    assign w_c[4] = g_g | (p_g & cin);
    assign cout   = w_c[4];
    assign s      = w_p ^ w_c[3:0];

    // Operands agree in sign but the result does not.
    assign ovf = (a[3] == b[3]) && (s[3] != a[3]);

endmodule

// File: rtl/psa_16bit.sv
// rtl/psa_16bit.sv - registered 16-bit add/sub with parallel 4x4-bit saturating mode
module psa_16bit
    import psa_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic              Sub,
    input  logic              pad,
    output logic [WIDTH-1:0]  Sum,
    output logic              Ovfl
);

    logic [WIDTH-1:0]    w_b_eff;
    logic [WIDTH-1:0]    w_raw;
    logic [WIDTH-1:0]    w_sum;
    logic [NUM_NIBS-1:0] w_cin;
    logic [NUM_NIBS-1:0] w_cout;
    logic [NUM_NIBS-1:0] w_ovf;
    logic [NUM_NIBS-1:0] w_pg;
    logic [NUM_NIBS-1:0] w_gg;
    logic                w_ovfl;
    logic                w_unused_cout;

    logic [WIDTH-1:0]    r_sum;
    logic                r_ovfl;

    assign w_b_eff = Sub ? ~B : B;

    // Block-level lookahead chain; sub-word mode isolates each nibble at the subtract carry-in.
    assign w_cin[0] = Sub;
    genvar gi;
    generate
        for (gi = 1; gi < NUM_NIBS; gi++) begin : g_carry
            assign w_cin[gi] = pad ? Sub : (w_gg[gi-1] | (w_pg[gi-1] & w_cin[gi-1]));
        end

        for (gi = 0; gi < NUM_NIBS; gi++) begin : g_nib
            cla_4bit u_cla (
                .a    (A[gi*NIB +: NIB]),
                .b    (w_b_eff[gi*NIB +: NIB]),
                .cin  (w_cin[gi]),
                .s    (w_raw[gi*NIB +: NIB]),
                .cout (w_cout[gi]),
                .ovf  (w_ovf[gi]),
                .p_g  (w_pg[gi]),
                .g_g  (w_gg[gi])
            );

            assign w_sum[gi*NIB +: NIB] = (pad && w_ovf[gi]) ? sat_nib(A[gi*NIB + NIB - 1])
                                                             : w_raw[gi*NIB +: NIB];
        end
    endgenerate

    assign w_unused_cout = ^w_cout;

    // In 16-bit mode only the top slice's sign rule applies.
    assign w_ovfl = pad ? (|w_ovf) : w_ovf[NUM_NIBS-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sum  <= '0;
            r_ovfl <= 1'b0;
        end else begin
            r_sum  <= w_sum;
            r_ovfl <= w_ovfl;
        end
    end

    assign Sum  = r_sum;
    assign Ovfl = r_ovfl;

endmodule

// File: tb/tb_psa_16bit.sv
// tb/tb_psa_16bit.sv - directed self-checking bench for psa_16bit
module tb_psa_16bit;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        pad;
    logic [15:0] sum;
    logic        ovfl;

    int n_cmp;
    int n_err;

    psa_16bit dut (
        .i_clk (clk),
        .i_rst (rst),
        .A     (a),
        .B     (b),
        .Sub   (sub),
        .pad   (pad),
        .Sum   (sum),
        .Ovfl  (ovfl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] exp_sum, input logic exp_ovfl);
        n_cmp++;
        assert ({sum, ovfl} === {exp_sum, exp_ovfl})
        else begin
            n_err++;
            $error("FAIL %s: got Sum=%h Ovfl=%b, expected Sum=%h Ovfl=%b",
                   tag, sum, ovfl, exp_sum, exp_ovfl);
        end
    endtask

    task automatic step(input logic [15:0] va, input logic [15:0] vb,
                        input logic vsub, input logic vpad);
        a   = va;
        b   = vb;
        sub = vsub;
        pad = vpad;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; pad = 1'b0;
        @(posedge clk);
        #1;
        check("reset_state", 16'h0000, 1'b0);
        rst = 1'b0;

        step(16'h0000, 16'h0002, 1'b0, 1'b0); check("inc_by_2",       16'h0002, 1'b0);
        step(16'h7FFF, 16'h0001, 1'b0, 1'b0); check("add_wrap",       16'h8000, 1'b1);
        step(16'h0005, 16'h0007, 1'b1, 1'b0); check("sub_neg",        16'hFFFE, 1'b0);
        step(16'h8000, 16'h0001, 1'b1, 1'b0); check("sub_wrap",       16'h7FFF, 1'b1);
        step(16'h0000, 16'h8000, 1'b1, 1'b0); check("sub_min",        16'h8000, 1'b1);
        step(16'h7123, 16'h1111, 1'b0, 1'b1); check("pad_sat_pos",    16'h7234, 1'b1);
        step(16'h7123, 16'h1111, 1'b0, 1'b0); check("same_16bit",     16'h8234, 1'b1);
        step(16'h8000, 16'hF000, 1'b0, 1'b1); check("pad_sat_neg_add",16'h8000, 1'b1);
        step(16'h8000, 16'h1000, 1'b1, 1'b1); check("pad_sat_neg_sub",16'h8000, 1'b1);
        step(16'h00FF, 16'h0001, 1'b0, 1'b1); check("pad_no_carry",   16'h00F0, 1'b0);
        step(16'h00FF, 16'h0001, 1'b0, 1'b0); check("carry_16bit",    16'h0100, 1'b0);
        step(16'h7531, 16'h1234, 1'b1, 1'b1); check("pad_sub_plain",  16'h630D, 1'b0);
        step(16'h0007, 16'h000F, 1'b1, 1'b1); check("pad_sub_sat_pos",16'h0007, 1'b1);

        // Inputs changed mid-cycle must not reach the outputs before the edge.
        a = 16'h1111; b = 16'h2222; sub = 1'b0; pad = 1'b0;
        #2;
        check("hold_before_edge", 16'h0007, 1'b1);
        @(posedge clk);
        #1;
        check("latency_1", 16'h3333, 1'b0);

        rst = 1'b1;
        step(16'h1234, 16'h1111, 1'b0, 1'b0); check("reset_dominates", 16'h0000, 1'b0);
        rst = 1'b0;
        step(16'h1234, 16'h1111, 1'b0, 1'b0); check("after_reset",     16'h2345, 1'b0);
        step(16'h0001, 16'h0001, 1'b0, 1'b0); check("b2b_1",           16'h0002, 1'b0);
        step(16'h0002, 16'h0003, 1'b1, 1'b0); check("b2b_2",           16'hFFFF, 1'b0);
        step(16'h4444, 16'h4444, 1'b0, 1'b1); check("b2b_3",           16'h7777, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
